// File: rtl/inv_mix_columns_iter.sv
// Iterative AES InvMixColumns: one 128-bit state in, COLS_PER_CYCLE columns transformed per clock.
// Optional macro INV_MIX_FWD_MODE_EN adds a fwd_mode port selecting forward MixColumns per state.
module inv_mix_columns_iter #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
`ifdef INV_MIX_FWD_MODE_EN
  input  logic         fwd_mode,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  // Byte 0 (row 0 of column 0) is the most significant byte: in_data[127:120].
  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("inv_mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t       state, state_next;
  logic [127:0] st, st_next;
  logic [1:0]   col_cnt;
  logic         load;
  logic         last_col;
  logic         fwd_q;

  logic [31:0]  cols     [4];
  logic [31:0]  new_cols [4];
  logic [31:0]  col_res  [COLS_PER_CYCLE];
  logic [1:0]   col_idx  [COLS_PER_CYCLE];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Both matrices share the x2/x4/x8 chain; only the final XOR selection differs.
  function automatic logic [31:0] mix_col(input logic [31:0] c, input logic fwd);
    logic [7:0] a [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] b [4];
    logic [1:0] k0, k1, k2, k3;
    a[0] = c[31:24];
    a[1] = c[23:16];
    a[2] = c[15:8];
    a[3] = c[7:0];
    for (int k = 0; k < 4; k++) begin
      k0 = 2'(k);
      x2[k0] = xtime(a[k0]);
      x4[k0] = xtime(x2[k0]);
      x8[k0] = xtime(x4[k0]);
    end
    for (int k = 0; k < 4; k++) begin
      k0 = 2'(k);
      k1 = k0 + 2'd1;
      k2 = k0 + 2'd2;
      k3 = k0 + 2'd3;
      if (fwd)
        b[k0] = x2[k0] ^ (x2[k1] ^ a[k1]) ^ a[k2] ^ a[k3];
      else
        b[k0] = (x8[k0] ^ x4[k0] ^ x2[k0])
              ^ (x8[k1] ^ x2[k1] ^ a[k1])
              ^ (x8[k2] ^ x4[k2] ^ a[k2])
              ^ (x8[k3] ^ a[k3]);
    end
    return {b[0], b[1], b[2], b[3]};
  endfunction

  always_comb begin
    cols[0] = st[127:96];
    cols[1] = st[95:64];
    cols[2] = st[63:32];
    cols[3] = st[31:0];
  end

  for (genvar i = 0; i < COLS_PER_CYCLE; i++) begin : g_col
    assign col_idx[i] = col_cnt + 2'(i);
    assign col_res[i] = mix_col(cols[col_idx[i]], fwd_q);
  end

  always_comb begin
    for (int k = 0; k < 4; k++) new_cols[k] = cols[k];
    for (int i = 0; i < COLS_PER_CYCLE; i++) new_cols[col_idx[i]] = col_res[i];
    st_next = {new_cols[0], new_cols[1], new_cols[2], new_cols[3]};
  end

  assign last_col = ({1'b0, col_cnt} + 3'(COLS_PER_CYCLE)) == 3'd4;

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    load       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load       = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (last_col) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            load       = 1'b1;
            state_next = BUSY;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      st      <= '0;
      col_cnt <= '0;
    end else begin
      state <= state_next;
      if (load) begin
        st      <= in_data;
        col_cnt <= '0;
      end else if (state == BUSY) begin
        st      <= st_next;
        col_cnt <= col_cnt + COL_STEP;
      end
    end
  end

`ifdef INV_MIX_FWD_MODE_EN
  always_ff @(posedge clk) begin
    if (rst)       fwd_q <= 1'b0;
    else if (load) fwd_q <= fwd_mode;
  end
`else
  assign fwd_q = 1'b0;
`endif

  assign out_data = st;

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// Directed bench for inv_mix_columns_iter: three widths (1/2/4 columns per cycle) on shared inputs,
// detailed handshake checks on the 1-column instance.
module tb_inv_mix_columns_iter;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [127:0] in_data;
  logic         out_ready;
  logic         ir [3];
  logic         ov [3];
  logic [127:0] od [3];
`ifdef INV_MIX_FWD_MODE_EN
  logic         fwd_mode;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  inv_mix_columns_iter #(.COLS_PER_CYCLE(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
`ifdef INV_MIX_FWD_MODE_EN
    .fwd_mode(fwd_mode),
`endif
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]));

  inv_mix_columns_iter #(.COLS_PER_CYCLE(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
`ifdef INV_MIX_FWD_MODE_EN
    .fwd_mode(fwd_mode),
`endif
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]));

  inv_mix_columns_iter #(.COLS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data),
`ifdef INV_MIX_FWD_MODE_EN
    .fwd_mode(fwd_mode),
`endif
    .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Waits (bounded) at negedges for out_valid of the 1-column instance; n counts edges passed.
  task automatic wait_out(output int n);
    n = 0;
    @(negedge clk);
    while (!ov[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  localparam logic [127:0] VEC_IN  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] VEC_OUT = 128'hdb135345_f20a225c_01010101_c6c6c6c6;

  // Known AES MixColumns column pairs: col_in -> InvMix -> col_ex.
  logic [31:0]  col_in [6];
  logic [31:0]  col_ex [6];
  logic [127:0] s_in   [8];
  logic [127:0] s_ex   [8];

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat [3];
    bit seen [3];
    int exp_lat [3];
    int n, cyc, last, sent, rcv;
    bit took, bad;

    col_in = '{32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6, 32'hd5d5d7d6, 32'h4d7ebdf8};
    col_ex = '{32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6, 32'hd4d4d4d5, 32'h2d26314c};
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 4; j++) begin
        int c;
        c = (i < 6) ? (i + j) % 6 : (i + 3 - j) % 6;
        s_in[i][127 - 32*j -: 32] = col_in[c];
        s_ex[i][127 - 32*j -: 32] = col_ex[c];
      end
    end
    exp_lat = '{4, 2, 1};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
`ifdef INV_MIX_FWD_MODE_EN
    fwd_mode = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 128'(ir[0]), 128'd1);
    chk("rst_out_valid", 128'(ov[0]), 128'd0);
    chk("rst_out_data", od[0], 128'd0);
    rst = 1'b0;

    // Vector on all three widths: latency, data and one-cycle out_valid pulse.
    @(negedge clk);
    in_data = VEC_IN; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; in_data = '0;
    for (int d = 0; d < 3; d++) begin lat[d] = 99; seen[d] = 1'b0; end
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (ov[d] && !seen[d]) begin
          seen[d] = 1'b1;
          lat[d]  = t;
          chk($sformatf("vec_data_w%0d", d), od[d], VEC_OUT);
        end else if (seen[d] && t == lat[d] + 1) begin
          chk($sformatf("vec_pulse_w%0d", d), 128'(ov[d]), 128'd0);
        end
      end
      @(posedge clk);
    end
    for (int d = 0; d < 3; d++) chk($sformatf("vec_latency_w%0d", d), 128'(lat[d]), 128'(exp_lat[d]));

    // Backpressure: hold DONE for 10 cycles, then consume and capture the next state on one edge.
    @(negedge clk);
    in_data = s_in[1]; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1 in_data = s_in[2];
    wait_out(n);
    chk("bp_latency", 128'(n), 128'd4);
    bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (od[0] !== s_ex[1] || ir[0] !== 1'b0 || ov[0] !== 1'b1) bad = 1'b1;
      @(negedge clk);
    end
    chk("bp_hold_stable", 128'(bad), 128'd0);
    chk("bp_hold_data", od[0], s_ex[1]);
    out_ready = 1'b1;
    #1 chk("bp_release_in_ready", 128'(ir[0]), 128'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("bp_capture_busy", 128'(ov[0]), 128'd0);
    n = 0;
    while (!ov[0] && n < 20) begin @(negedge clk); n++; end
    chk("bp_next_latency", 128'(n), 128'd4);
    chk("bp_next_data", od[0], s_ex[2]);
    repeat (2) @(negedge clk);

    // Back-to-back stream of 8 states with out_ready tied high.
    @(posedge clk);
    #1 in_valid = 1'b1; in_data = s_in[0];
    sent = 0; rcv = 0; cyc = 0; last = 0;
    while (rcv < 8 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (ov[0]) begin
        chk($sformatf("stream_data_%0d", rcv), od[0], s_ex[rcv]);
        if (rcv > 0) chk($sformatf("stream_gap_%0d", rcv), 128'(cyc - last), 128'd5);
        last = cyc;
        rcv++;
      end
      took = in_valid && ir[0];
      @(posedge clk);
      #1;
      if (took) begin
        sent++;
        if (sent < 8) in_data = s_in[sent];
        else in_valid = 1'b0;
      end
    end
    chk("stream_count", 128'(rcv), 128'd8);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Reset while BUSY with col_cnt=2: everything discarded.
    in_data = VEC_IN; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 128'(ir[0]), 128'd1);
    chk("midrst_out_valid", 128'(ov[0]), 128'd0);
    chk("midrst_out_data", od[0], 128'd0);
    rst = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ov[0] !== 1'b0) bad = 1'b1;
    end
    chk("midrst_no_output", 128'(bad), 128'd0);

`ifdef INV_MIX_FWD_MODE_EN
    in_data = 128'hdb135345_f20a225c_d4d4d4d5_2d26314c; in_valid = 1'b1; fwd_mode = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; fwd_mode = 1'b0;
    wait_out(n);
    chk("fwd_latency", 128'(n), 128'd4);
    chk("fwd_data", od[0], 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8);
    @(negedge clk);
    in_data = 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8; in_valid = 1'b1; fwd_mode = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_out(n);
    chk("fwd_inv_latency", 128'(n), 128'd4);
    chk("fwd_inv_data", od[0], 128'hdb135345_f20a225c_d4d4d4d5_2d26314c);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
